// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : UART (8N1) program downloader. Receives an image frame
//               A5 | CNT_L | CNT_H | CNT*4 data bytes | CSUM, packs the data
//               bytes little-endian into 32-bit words and writes them to the
//               instruction ROM from word 0 while holding the core halted.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 115200,
   parameter int ADDR_W    = 12,
   parameter int MAX_WORDS = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   input  logic              dl_en,
   output logic              halt_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int BIT_CYC = CLK_FREQ / BAUD;
   localparam int HALF    = BIT_CYC / 2;
   localparam int CW      = $clog2(BIT_CYC + 1);
   localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] C_BIT_M1  = CW'(BIT_CYC - 1);
   localparam logic [15:0]   C_MAX     = 16'(MAX_WORDS);
   localparam logic [7:0]    C_SYNC    = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE, S_CNT_L, S_CNT_H, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   // ---------------- receiver ----------------
   logic          r_rx_s1, r_rx_s2, r_rx_d;
   logic          r_rx_busy;
   logic [CW-1:0] r_rx_cnt;
   logic [3:0]    r_rx_bit;
   logic [7:0]    r_rx_sh;
   logic          r_byte_vld;
   logic          r_frm_err;
   logic          w_rx_fall;
   logic          w_rx_tick;

   assign w_rx_fall = r_rx_d & ~r_rx_s2;
   // Start bit is rechecked at half a bit; every later bit one full bit apart.
   assign w_rx_tick = (r_rx_bit == 4'd0) ? (r_rx_cnt == C_HALF_M1) : (r_rx_cnt == C_BIT_M1);

   // Synchronise the asynchronous serial line and keep a delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_rx_s1 <= uart_rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_d  <= r_rx_s2;
      end
   end

   // Bit sampler: arms on a falling edge, rejects glitches, shifts LSB first, flags stop bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_busy  <= 1'b0;
         r_rx_cnt   <= '0;
         r_rx_bit   <= 4'd0;
         r_rx_sh    <= 8'h00;
         r_byte_vld <= 1'b0;
         r_frm_err  <= 1'b0;
      end else begin
         r_byte_vld <= 1'b0;
         r_frm_err  <= 1'b0;
         if (!r_rx_busy) begin
            if (w_rx_fall) begin
               r_rx_busy <= 1'b1;
               r_rx_cnt  <= '0;
               r_rx_bit  <= 4'd0;
            end
         end else if (w_rx_tick) begin
            r_rx_cnt <= '0;
            if (r_rx_bit == 4'd0) begin
               if (r_rx_s2) r_rx_busy <= 1'b0;
               else         r_rx_bit  <= 4'd1;
            end else if (r_rx_bit == 4'd9) begin
               r_rx_busy <= 1'b0;
               if (r_rx_s2) r_byte_vld <= 1'b1;
               else         r_frm_err  <= 1'b1;
            end else begin
               r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
               r_rx_bit <= r_rx_bit + 4'd1;
            end
         end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
         end
      end
   end

   // ---------------- frame FSM ----------------
   state_t            r_state;
   logic              r_halt, r_we, r_done, r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [7:0]        r_sum;
   logic [7:0]        r_cnt_l;
   logic [15:0]       r_wleft;
   logic [1:0]        r_k;
   logic [23:0]       r_word;
   logic [15:0]       w_cnt;

   assign w_cnt = {r_rx_sh, r_cnt_l};

   // Frame parser: advances on received bytes, drives ROM writes and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_halt  <= 1'b0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'h0;
         r_sum   <= 8'h00;
         r_cnt_l <= 8'h00;
         r_wleft <= 16'h0;
         r_k     <= 2'd0;
         r_word  <= 24'h0;
      end else if (!dl_en) begin
         r_state <= S_IDLE;
         r_halt  <= 1'b0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_we <= 1'b0;
         // Advance only between words; after the last word the address stays put.
         if (r_we && r_state == S_DATA) r_addr <= r_addr + ADDR_W'(1);
         if (r_frm_err) begin
            if (r_state != S_IDLE) begin
               r_state <= S_ERR;
               r_halt  <= 1'b1;
               r_done  <= 1'b0;
               r_err   <= 1'b1;
            end
         end else if (r_byte_vld) begin
            case (r_state)
               S_IDLE, S_DONE, S_ERR: begin
                  if (r_rx_sh == C_SYNC) begin
                     r_state <= S_CNT_L;
                     r_halt  <= 1'b1;
                     r_done  <= 1'b0;
                     r_err   <= 1'b0;
                     r_addr  <= '0;
                     r_sum   <= 8'h00;
                  end
               end
               S_CNT_L: begin
                  r_cnt_l <= r_rx_sh;
                  r_sum   <= r_sum + r_rx_sh;
                  r_state <= S_CNT_H;
               end
               S_CNT_H: begin
                  r_sum   <= r_sum + r_rx_sh;
                  r_wleft <= w_cnt;
                  r_k     <= 2'd0;
                  if (w_cnt > C_MAX) begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end else if (w_cnt == 16'h0) begin
                     r_state <= S_CSUM;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
               S_DATA: begin
                  r_sum <= r_sum + r_rx_sh;
                  r_k   <= r_k + 2'd1;
                  case (r_k)
                     2'd0: r_word[7:0]   <= r_rx_sh;
                     2'd1: r_word[15:8]  <= r_rx_sh;
                     2'd2: r_word[23:16] <= r_rx_sh;
                     default: begin
                        r_we    <= 1'b1;
                        r_wdata <= {r_rx_sh, r_word};
                        r_wleft <= r_wleft - 16'd1;
                        if (r_wleft == 16'd1) r_state <= S_CSUM;
                     end
                  endcase
               end
               S_CSUM: begin
                  if (r_rx_sh == r_sum) begin
                     r_state <= S_DONE;
                     r_halt  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign halt_o      = r_halt;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign done_o      = r_done;
   assign err_o       = r_err;

endmodule
`default_nettype wire
